// File: rtl/sci_arb_pkg.sv
// Shared types and constants for the SCI TX arbiter: FSM encoding,
// requester count, grant ID width and timeout counter width.
package sci_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Round-robin successor; wraps 3 -> 0 through the 2-bit truncation.
  function automatic logic [ID_W-1:0] nextId(input logic [ID_W-1:0] id);
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/sci_tx_arbiter_if.sv
// Requester, grant-status and UART write-port bundle for sci_tx_arbiter,
// plus read-only debug taps of the arbiter FSM.
interface sci_tx_arbiter_if;
  import sci_arb_pkg::*;

  // Handshake: requester i holds iREQ_VALID[i], its DATA byte and LAST stable
  // until oREQ_ACK[i] is high in a cycle; the byte transfers on that clock edge.
  // oREQ_ACK is combinational from iREQ_VALID and iUART_TX_BUSY, and every ACK
  // coincides with exactly one oUART_TX_REQ write carrying the same byte.
  logic                 iENABLE;
  logic [NUM_REQ-1:0]   iREQ_VALID;
  logic [8*NUM_REQ-1:0] iREQ_DATA;
  logic [NUM_REQ-1:0]   iREQ_LAST;
  logic [NUM_REQ-1:0]   oREQ_ACK;
  logic                 oGRANT_VALID;
  logic [ID_W-1:0]      oGRANT_ID;
  logic                 oTIMEOUT;
  logic                 oUART_TX_REQ;
  logic [7:0]           oUART_TX_DATA;
  logic                 iUART_TX_BUSY;

  arb_state_e           dbgState;
  logic [ID_W-1:0]      dbgPtr;
  logic [CNT_W-1:0]     dbgCount;

  modport slave (
    input  iENABLE, iREQ_VALID, iREQ_DATA, iREQ_LAST, iUART_TX_BUSY,
    output oREQ_ACK, oGRANT_VALID, oGRANT_ID, oTIMEOUT, oUART_TX_REQ,
    output oUART_TX_DATA, dbgState, dbgPtr, dbgCount
  );

  modport master (
    output iENABLE, iREQ_VALID, iREQ_DATA, iREQ_LAST, iUART_TX_BUSY,
    input  oREQ_ACK, oGRANT_VALID, oGRANT_ID, oTIMEOUT, oUART_TX_REQ,
    input  oUART_TX_DATA, dbgState, dbgPtr, dbgCount
  );

endinterface

// File: rtl/sci_rr_pick.sv
// Combinational rotating-priority encoder: first set bit of reqVec searching
// ptr, ptr+1, ... modulo the requester count.
module sci_rr_pick
  import sci_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = ptr + off[ID_W-1:0];
      if (reqVec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sci_tx_arbiter.sv
// Round-robin arbiter sharing the SCI TX FIFO write port among four byte
// streams; a grant covers a whole message and is reclaimed on idle timeout.
module sci_tx_arbiter
  import sci_arb_pkg::*;
#(
  parameter int unsigned P_N       = 4,
  parameter logic [15:0] P_TIMEOUT = 16'd4096
) (
  input  logic             iCLOCK,
  input  logic             iRESET,
  input  logic             iRESET_SYNC,
  sci_tx_arbiter_if.slave  bus
);

  arb_state_e       state;
  arb_state_e       stateNext;
  logic [ID_W-1:0]  ownerId;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] count;

  logic             pickFound;
  logic [ID_W-1:0]  pickIdx;
  logic             grantLoad;
  logic             releaseGrant;

  logic             locked;
  logic             ownerValid;
  logic             ownerLast;
  logic [7:0]       ownerData;
  logic             accept;
  logic             timeoutHit;
  logic [P_N-1:0]   ackVec;

  sci_rr_pick u_pick (
    .reqVec (bus.iREQ_VALID),
    .ptr    (ptr),
    .found  (pickFound),
    .idx    (pickIdx)
  );

  // A pending synchronous clear suppresses the ACK so the byte is re-presented.
  always_comb begin
    locked     = (state == LOCKED);
    ownerValid = bus.iREQ_VALID[ownerId];
    ownerLast  = bus.iREQ_LAST[ownerId];
    ownerData  = bus.iREQ_DATA[{ownerId, 3'b000} +: 8];
    accept     = locked && ownerValid && !bus.iUART_TX_BUSY && !iRESET_SYNC;
    timeoutHit = locked && !ownerValid && !iRESET_SYNC &&
                 (count == P_TIMEOUT - 16'd1);
    ackVec     = accept ? ({{(P_N-1){1'b0}}, 1'b1} << ownerId) : '0;
  end

  always_comb begin
    stateNext    = state;
    grantLoad    = 1'b0;
    releaseGrant = 1'b0;
    case (state)
      IDLE: begin
        if (bus.iENABLE && pickFound) begin
          stateNext = LOCKED;
          grantLoad = 1'b1;
        end
      end
      LOCKED: begin
        if ((accept && ownerLast) || timeoutHit) begin
          stateNext    = IDLE;
          releaseGrant = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state <= IDLE;
    end else if (iRESET_SYNC) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FIFO-full stalls keep the owner's VALID high, so they never age the grant.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      ownerId <= '0;
      ptr     <= '0;
      count   <= '0;
    end else if (iRESET_SYNC) begin
      ownerId <= '0;
      ptr     <= '0;
      count   <= '0;
    end else begin
      if (grantLoad) begin
        ownerId <= pickIdx;
      end
      if (releaseGrant) begin
        ptr <= nextId(ownerId);
      end
      if (grantLoad || accept) begin
        count <= '0;
      end else if (locked && !ownerValid) begin
        count <= count + 16'd1;
      end
    end
  end

  assign bus.oREQ_ACK      = ackVec;
  assign bus.oUART_TX_REQ  = accept;
  assign bus.oUART_TX_DATA = accept ? ownerData : 8'h00;
  assign bus.oTIMEOUT      = timeoutHit;
  assign bus.oGRANT_VALID  = locked;
  assign bus.oGRANT_ID     = ownerId;

  assign bus.dbgState      = state;
  assign bus.dbgPtr        = ptr;
  assign bus.dbgCount      = count;

endmodule

// File: tb/tb_sci_tx_arbiter.sv
// Scoreboard bench for sci_tx_arbiter: directed messages push expected
// {id,byte} pairs; a monitor pops and compares on every UART write.
module tb_sci_tx_arbiter;
  import sci_arb_pkg::*;

  localparam logic [15:0] TMO = 16'd8;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst;
  logic rstSync;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sci_tx_arbiter_if bus ();

  sci_tx_arbiter #(.P_N(4), .P_TIMEOUT(TMO)) dut (
    .iCLOCK      (clk),
    .iRESET      (rst),
    .iRESET_SYNC (rstSync),
    .bus         (bus)
  );

  logic [W-1:0] exp_q[$];
  int txCyc[$];
  int checks = 0;
  int failures = 0;
  int timeoutCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expectByte(input int r, input logic [7:0] d);
    exp_q.push_back({2'(r), d});
  endtask

  task automatic sendByte(input int r, input logic [7:0] d, input logic last);
    logic done;
    done = 1'b0;
    bus.iREQ_VALID[r]      = 1'b1;
    bus.iREQ_DATA[8*r +: 8] = d;
    bus.iREQ_LAST[r]       = last;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (bus.oREQ_ACK[r]) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL ack_wait: requester %0d byte %02h got no ACK expected ACK within 60 cycles", r, d);
    end
    @(posedge clk);
    #1;
    bus.iREQ_VALID[r] = 1'b0;
    bus.iREQ_LAST[r]  = 1'b0;
  endtask

  task automatic sendMsg(input int r, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) sendByte(r, first + 8'(k), (k == n - 1));
  endtask

  task automatic waitAcks(input int r, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 60 && seen < n; i++) begin
      @(negedge clk);
      if (bus.oREQ_ACK[r]) seen++;
    end
    if (seen < n) begin
      checks++;
      failures++;
      $display("FAIL ack_count: requester %0d got %0d ACKs expected %0d", r, seen, n);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_grant_valid"}, bus.oGRANT_VALID, 0);
    check({tag, "_grant_id"}, bus.oGRANT_ID, 0);
    check({tag, "_timeout"}, bus.oTIMEOUT, 0);
    check({tag, "_ack"}, bus.oREQ_ACK, 0);
    check({tag, "_tx_req"}, bus.oUART_TX_REQ, 0);
    check({tag, "_tx_data"}, bus.oUART_TX_DATA, 0);
    check({tag, "_state"}, bus.dbgState, IDLE);
    check({tag, "_ptr"}, bus.dbgPtr, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int t0;
    int tc0;
    rst = 1'b1;
    rstSync = 1'b0;
    bus.iENABLE = 1'b1;
    bus.iREQ_VALID = '0;
    bus.iREQ_DATA = '0;
    bus.iREQ_LAST = '0;
    bus.iUART_TX_BUSY = 1'b0;

    // Monitor: every UART write must match the head of the expected queue.
    fork
      forever begin
        logic [W-1:0] e;
        @(negedge clk);
        if (bus.oTIMEOUT) timeoutCnt++;
        if (bus.oUART_TX_REQ) begin
          txCyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected: got id=%0d data=%02h expected no write",
                     bus.oGRANT_ID, bus.oUART_TX_DATA);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", {bus.oGRANT_ID, bus.oUART_TX_DATA}, e);
            check("tx_ack_onehot", bus.oREQ_ACK, 4'b0001 << bus.oGRANT_ID);
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Requester 0: 41,42,43 back to back, first write the cycle after grant
    base = txCyc.size();
    expectByte(0, 8'h41); expectByte(0, 8'h42); expectByte(0, 8'h43);
    t0 = cyc;
    sendMsg(0, 8'h41, 3);
    check("a_first_latency", txCyc[base] - t0, 1);
    check("a_gap1", txCyc[base+1] - txCyc[base], 1);
    check("a_gap2", txCyc[base+2] - txCyc[base+1], 1);
    @(negedge clk);
    check("a_idle_after", bus.dbgState, IDLE);
    check("a_ptr", bus.dbgPtr, 1);
    check("a_grant_id_held", bus.oGRANT_ID, 0);

    // All four single-byte messages from reset: 10,11,12,13 two cycles apart
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    base = txCyc.size();
    for (int i = 0; i < 4; i++) expectByte(i, 8'h10 + 8'(i));
    fork
      sendByte(0, 8'h10, 1'b1);
      sendByte(1, 8'h11, 1'b1);
      sendByte(2, 8'h12, 1'b1);
      sendByte(3, 8'h13, 1'b1);
    join
    for (int i = 0; i < 3; i++) check("b_handover_gap", txCyc[base+i+1] - txCyc[base+i], 2);
    check("b_ptr_wrap", bus.dbgPtr, 0);
    base = txCyc.size();
    expectByte(0, 8'h20);
    t0 = cyc;
    sendByte(0, 8'h20, 1'b1);
    check("b_req0_again", txCyc[base] - t0, 1);

    // Requester 1, four bytes, FIFO busy for 5 cycles after byte 2
    base = txCyc.size();
    tc0 = timeoutCnt;
    for (int i = 0; i < 4; i++) expectByte(1, 8'hC0 + 8'(i));
    fork
      sendMsg(1, 8'hC0, 4);
      begin
        waitAcks(1, 2);
        @(posedge clk); #1 bus.iUART_TX_BUSY = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("c_stall_ack", bus.oREQ_ACK, 0);
          check("c_stall_tx_req", bus.oUART_TX_REQ, 0);
        end
        @(posedge clk); #1 bus.iUART_TX_BUSY = 1'b0;
      end
    join
    check("c_resume_gap", txCyc[base+2] - txCyc[base+1], 6);
    check("c_no_timeout", timeoutCnt - tc0, 0);

    // Timeout (P_TIMEOUT=8): requester 2 stalls, requester 3 waits
    tc0 = timeoutCnt;
    expectByte(2, 8'h55); expectByte(3, 8'h66);
    fork
      begin
        sendByte(2, 8'h55, 1'b0);
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          check("d_timeout_pulse", bus.oTIMEOUT, 32'(k == 7));
        end
        @(negedge clk);
        check("d_idle_after_timeout", bus.oGRANT_VALID, 0);
        @(negedge clk);
        check("d_regrant_valid", bus.oGRANT_VALID, 1);
        check("d_regrant_id", bus.oGRANT_ID, 3);
      end
      sendByte(3, 8'h66, 1'b1);
    join
    check("d_timeout_count", timeoutCnt - tc0, 1);

    // No interleaving: requester 2 joins after requester 0's first byte
    base = txCyc.size();
    for (int i = 0; i < 4; i++) expectByte(0, 8'hA0 + 8'(i));
    expectByte(2, 8'hB0); expectByte(2, 8'hB1);
    fork
      sendMsg(0, 8'hA0, 4);
      begin
        waitAcks(0, 1);
        @(posedge clk); #1;
        sendMsg(2, 8'hB0, 2);
      end
    join
    check("e_handover_gap", txCyc[base+4] - txCyc[base+3], 2);

    // Enable low blocks new grants only; an in-flight message completes
    bus.iENABLE = 1'b0;
    expectByte(1, 8'h70); expectByte(1, 8'h71);
    fork
      sendMsg(1, 8'h70, 2);
      begin
        repeat (3) begin
          @(negedge clk);
          check("g_no_grant_disabled", bus.oGRANT_VALID, 0);
        end
        @(posedge clk); #1 bus.iENABLE = 1'b1;
        waitAcks(1, 1);
        @(posedge clk); #1 bus.iENABLE = 1'b0;
      end
    join
    bus.iREQ_VALID[3] = 1'b1;
    bus.iREQ_DATA[31:24] = 8'h7F;
    bus.iREQ_LAST[3] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("g_no_grant_after", bus.oGRANT_VALID, 0);
    end
    @(posedge clk); #1 bus.iENABLE = 1'b1;
    expectByte(3, 8'h7F);
    sendByte(3, 8'h7F, 1'b1);

    // Asynchronous reset mid-message, then lowest valid index wins
    expectByte(1, 8'hE1);
    bus.iREQ_VALID[1] = 1'b1;
    bus.iREQ_DATA[15:8] = 8'hE1;
    bus.iREQ_LAST[1] = 1'b0;
    waitAcks(1, 1);
    @(posedge clk); #1 bus.iREQ_DATA[15:8] = 8'hE2;
    #1 rst = 1'b1;
    #1 checkAllZero("async_rst");
    bus.iREQ_LAST[1] = 1'b1;
    bus.iREQ_VALID[3] = 1'b1;
    bus.iREQ_DATA[31:24] = 8'h33;
    bus.iREQ_LAST[3] = 1'b1;
    expectByte(1, 8'hE2); expectByte(3, 8'h33);
    @(posedge clk); #1 rst = 1'b0;
    fork
      sendByte(1, 8'hE2, 1'b1);
      sendByte(3, 8'h33, 1'b1);
    join

    // Synchronous clear mid-message: no ACK for the pending byte
    expectByte(2, 8'hC1);
    bus.iREQ_VALID[2] = 1'b1;
    bus.iREQ_DATA[23:16] = 8'hC1;
    bus.iREQ_LAST[2] = 1'b0;
    waitAcks(2, 1);
    @(posedge clk); #1;
    bus.iREQ_DATA[23:16] = 8'hC2;
    rstSync = 1'b1;
    @(negedge clk);
    check("sync_rst_no_ack", bus.oREQ_ACK, 0);
    check("sync_rst_no_tx", bus.oUART_TX_REQ, 0);
    @(posedge clk); #1;
    checkAllZero("sync_rst");
    rstSync = 1'b0;
    bus.iREQ_LAST[2] = 1'b1;
    expectByte(0, 8'h0C); expectByte(2, 8'hC2);
    fork
      sendByte(0, 8'h0C, 1'b1);
      sendByte(2, 8'hC2, 1'b1);
    join

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
